// File: rtl/op_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : op_fetch
//  Purpose  : Instruction fetch stage for the GCore op path. Owns the program
//             counter, issues reads to the op memory controller, captures the
//             op returned one cycle later into a 2-entry buffer and presents
//             the buffer head to the decoder over valid/ready. Stalls while
//             the loader writes op memory, redirects on jump, stops on HALT_OP.
//  Ports    : clk, rst          - clock, asynchronous active-high reset
//             start, start_addr - begin fetching (IDLE/HALT only)
//             write             - loader busy; suppresses read issue
//             addr, op          - op memory read address / returned data
//             jump, jump_addr   - decoder redirect (RUN only)
//             op_out, op_pc,
//             op_valid, op_ready- decoder handshake (buffer head)
//             busy, halted      - state is RUN / state is HALT
//  Revision : 1.0 - initial release
// ============================================================================
module op_fetch #(
    parameter int                ADDR_W  = 4,
    parameter int                OP_W    = 8,
    parameter logic [OP_W-1:0]   HALT_OP = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              write,
    output logic [ADDR_W-1:0] addr,
    input  logic [OP_W-1:0]   op,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [OP_W-1:0]   op_out,
    output logic [ADDR_W-1:0] op_pc,
    output logic              op_valid,
    input  logic              op_ready,
    output logic              busy,
    output logic              halted
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_halt = 2'd2;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_if_pc;
    logic [1:0]        r_cnt;
    logic [OP_W-1:0]   r_buf_op [2];
    logic [ADDR_W-1:0] r_buf_pc [2];

    logic       w_run;
    logic       w_pop;
    logic       w_is_halt;
    logic       w_jump;
    logic       w_start;
    logic       w_push;
    logic       w_slot;
    logic [2:0] w_occ;
    logic       w_issue;

    assign w_run     = (r_state == c_st_run);
    assign w_pop     = op_valid && op_ready;
    assign w_jump    = jump && w_run;
    assign w_start   = start && (r_state == c_st_idle || r_state == c_st_halt);
    // Data on 'op' is meaningful only the cycle after an issue.
    assign w_is_halt = r_inflight && (op == HALT_OP);
    assign w_push    = r_inflight && !w_is_halt && !w_jump;

    // Occupancy the buffer would reach if the pending read lands: the read in
    // flight already holds a slot, so a new issue needs strictly under 2.
    assign w_occ   = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    // No issue on the halt-capture edge so addr stays at the op after the halt.
    assign w_issue = w_run && !write && !w_jump && !w_is_halt && (w_occ < 3'd2);

    // Slot for the pushed entry after any pop has shifted the head out.
    assign w_slot = (r_cnt == 2'd2) ? 1'b1 : (r_cnt[0] & ~w_pop);

    assign addr     = r_pc;
    assign op_out   = r_buf_op[0];
    assign op_pc    = r_buf_pc[0];
    assign op_valid = (r_cnt != 2'd0);
    assign busy     = w_run;
    assign halted   = (r_state == c_st_halt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_pc        <= '0;
            r_inflight  <= 1'b0;
            r_if_pc     <= '0;
            r_cnt       <= 2'd0;
            r_buf_op[0] <= '0;
            r_buf_op[1] <= '0;
            r_buf_pc[0] <= '0;
            r_buf_pc[1] <= '0;
        end else begin
            // A jump or start always coincides with no issue, so this also
            // discards any read in flight on those cycles and on halt.
            r_inflight <= w_issue;
            if (w_issue) begin
                r_if_pc <= r_pc;
            end

            if (w_start) begin
                r_pc <= start_addr;
            end else if (w_jump) begin
                r_pc <= jump_addr;
            end else if (w_issue) begin
                r_pc <= r_pc + 1'b1;
            end

            case (r_state)
                c_st_idle: if (w_start) r_state <= c_st_run;
                c_st_run:  if (w_is_halt && !w_jump) r_state <= c_st_halt;
                c_st_halt: if (w_start) r_state <= c_st_run;
                default:   r_state <= c_st_idle;
            endcase

            if (w_start || w_jump) begin
                r_cnt <= 2'd0;
            end else begin
                r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
                if (w_pop) begin
                    r_buf_op[0] <= r_buf_op[1];
                    r_buf_pc[0] <= r_buf_pc[1];
                end
                // Ordered after the shift so a push into slot 0 wins.
                if (w_push) begin
                    r_buf_op[w_slot] <= op;
                    r_buf_pc[w_slot] <= r_if_pc;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_op_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_op_fetch
//  Purpose  : Directed self-checking bench for op_fetch with a one-cycle
//             latency op memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_op_fetch;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] start_addr;
    logic       write;
    logic [3:0] addr;
    logic [7:0] op;
    logic       jump;
    logic [3:0] jump_addr;
    logic [7:0] op_out;
    logic [3:0] op_pc;
    logic       op_valid;
    logic       op_ready;
    logic       busy;
    logic       halted;

    int errors;
    int checks;

    logic [7:0] mem [16];

    op_fetch #(.ADDR_W(4), .OP_W(8), .HALT_OP(8'hFF)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .write      (write),
        .addr       (addr),
        .op         (op),
        .jump       (jump),
        .jump_addr  (jump_addr),
        .op_out     (op_out),
        .op_pc      (op_pc),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .busy       (busy),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Op memory: data for the address seen at an edge appears after it.
    always @(posedge clk) op <= mem[addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_op(input string tag, input logic [7:0] e_op, input logic [3:0] e_pc);
        chk({tag, ".valid"}, {31'd0, op_valid}, 32'd1);
        chk({tag, ".op"},    {24'd0, op_out},   {24'd0, e_op});
        chk({tag, ".pc"},    {28'd0, op_pc},    {28'd0, e_pc});
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".addr"},   {28'd0, addr},     32'd0);
        chk({tag, ".op_out"}, {24'd0, op_out},   32'd0);
        chk({tag, ".op_pc"},  {28'd0, op_pc},    32'd0);
        chk({tag, ".valid"},  {31'd0, op_valid}, 32'd0);
        chk({tag, ".busy"},   {31'd0, busy},     32'd0);
        chk({tag, ".halted"}, {31'd0, halted},   32'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h80 + 8'(i);
        mem[3]  = 8'h11; mem[4]  = 8'h22; mem[5] = 8'h33; mem[6] = 8'h44;
        mem[14] = 8'hA1; mem[15] = 8'hA2; mem[0] = 8'hA3;
        mem[2]  = 8'hFF;

        rst = 1'b1; start = 1'b0; start_addr = '0; write = 1'b0;
        jump = 1'b0; jump_addr = '0; op_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        chk_idle_outputs("reset");

        // Start at 3: ops 11,22,33,44 from edge k+2
        start = 1'b1; start_addr = 4'd3;
        step();                                   // edge k
        start = 1'b0;
        chk("start.addr", {28'd0, addr}, 32'd3);
        chk("start.busy", {31'd0, busy}, 32'd1);
        chk("start.valid_k", {31'd0, op_valid}, 32'd0);
        step();                                   // k+1
        chk("start.valid_k1", {31'd0, op_valid}, 32'd0);
        step(); chk_op("s0", 8'h11, 4'd3);
        step(); chk_op("s1", 8'h22, 4'd4);
        step(); chk_op("s2", 8'h33, 4'd5);
        step(); chk_op("s3", 8'h44, 4'd6);

        // Backpressure: 5 cycles op_ready low, head holds, no issue
        op_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_op("bp.hold", 8'h44, 4'd6);
            chk("bp.addr", {28'd0, addr}, 32'd8);
        end
        op_ready = 1'b1;
        step(); chk_op("bp.r0", 8'h87, 4'd7);
        step(); chk_op("bp.r1", 8'h88, 4'd8);

        // Jump to 12 with one op buffered and pc9 in flight
        op_ready = 1'b0; jump = 1'b1; jump_addr = 4'd12;
        step();                                   // edge j
        jump = 1'b0; op_ready = 1'b1;
        chk("jump.valid_j", {31'd0, op_valid}, 32'd0);
        chk("jump.addr", {28'd0, addr}, 32'd12);
        step();
        chk("jump.valid_j1", {31'd0, op_valid}, 32'd0);
        step(); chk_op("j0", 8'h8C, 4'd12);
        step(); chk_op("j1", 8'h8D, 4'd13);
        // Wrap 14,15,0 then 1, then halt op at 2
        step(); chk_op("w0", 8'hA1, 4'd14);
        step(); chk_op("w1", 8'hA2, 4'd15);
        step(); chk_op("w2", 8'hA3, 4'd0);
        step(); chk_op("w3", 8'h81, 4'd1);
        step();
        chk("halt.halted", {31'd0, halted}, 32'd1);
        chk("halt.busy", {31'd0, busy}, 32'd0);
        chk("halt.valid", {31'd0, op_valid}, 32'd0);
        chk("halt.addr", {28'd0, addr}, 32'd3);
        step(); step();
        chk("halt.stay", {31'd0, halted}, 32'd1);
        chk("halt.valid2", {31'd0, op_valid}, 32'd0);
        chk("halt.addr2", {28'd0, addr}, 32'd3);

        // Restart at 7
        start = 1'b1; start_addr = 4'd7;
        step();
        start = 1'b0;
        chk("rs.busy", {31'd0, busy}, 32'd1);
        chk("rs.halted", {31'd0, halted}, 32'd0);
        chk("rs.addr", {28'd0, addr}, 32'd7);
        step();
        step(); chk_op("rs0", 8'h87, 4'd7);

        // Loader write for 3 cycles: in-flight read completes, no new issue
        write = 1'b1;
        step(); chk_op("wr0", 8'h88, 4'd8);
        chk("wr.addr0", {28'd0, addr}, 32'd9);
        step();
        chk("wr.valid1", {31'd0, op_valid}, 32'd0);
        chk("wr.addr1", {28'd0, addr}, 32'd9);
        step();
        chk("wr.valid2", {31'd0, op_valid}, 32'd0);
        chk("wr.addr2", {28'd0, addr}, 32'd9);
        write = 1'b0;
        step();
        chk("wr.addr3", {28'd0, addr}, 32'd10);
        step(); chk_op("wr1", 8'h89, 4'd9);
        step(); chk_op("wr2", 8'h8A, 4'd10);

        // Asynchronous reset between edges
        #3 rst = 1'b1;
        #1;
        chk_idle_outputs("arst");
        step();
        rst = 1'b0;
        step();
        chk_idle_outputs("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/op_fetch.md
# op_fetch

Instruction fetch stage for the GCore op path. Owns the program counter, drives the read address of the op memory controller, captures the 8-bit ops it returns one cycle later, and hands them to the decoder through a valid/ready interface with a 2-entry buffer. It stalls while the loader writes op memory, redirects on decoder jumps and stops on a halt op.

## Interface
- ADDR_W, 4, op memory address width; PC wraps modulo 2^ADDR_W
- OP_W, 8, op width
- HALT_OP, 8'hFF, op value that stops fetching
- clk  input  1  single clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin fetching at start_addr; honoured only in IDLE or HALT
- start_addr  input  ADDR_W  first fetch address
- write  input  1  loader is writing op memory; no read is issued while high
- addr  output  ADDR_W  op memory read address (= PC register)
- op  input  OP_W  op memory data, valid the cycle after addr was presented with write low
- jump  input  1  decoder redirect; honoured only in RUN
- jump_addr  input  ADDR_W  redirect target
- op_out  output  OP_W  op presented to decoder (buffer head)
- op_pc  output  ADDR_W  address op_out was fetched from
- op_valid  output  1  op_out/op_pc valid
- op_ready  input  1  decoder accepts head when op_valid && op_ready
- busy  output  1  state is RUN
- halted  output  1  state is HALT

## Operation
- Reset: state IDLE, PC = 0, buffer empty, no read in flight; addr = 0, op_out = 0, op_pc = 0, op_valid = 0, busy = 0, halted = 0.
- States: IDLE -> RUN on start; RUN -> HALT when HALT_OP is captured; HALT -> RUN on start. No other transitions. start in RUN ignored; jump in IDLE/HALT ignored.
- Issue: in RUN a read is issued from PC in a cycle when write = 0 and (buffer count + in-flight - pop this cycle) < 2. On issue, PC increments (15 -> 0 wraps); the in-flight flag records issue PC.
- Capture: the cycle after an issue, op is written to the buffer with its PC. Exactly one read in flight at most.
- Buffer: 2-entry FIFO; push and pop in the same cycle allowed; never overflows by credit rule above.
- Halt: a captured HALT_OP is not pushed; the in-flight read (if any) is discarded; state -> HALT; ops already buffered remain and drain normally.
- Jump: PC <- jump_addr, buffer flushed, in-flight read discarded. If op_ready && op_valid in the same cycle, that head op counts as accepted. Jump in the same cycle as a HALT_OP capture: jump wins, state stays RUN.
- start in IDLE/HALT: PC <- start_addr, buffer flushed, state RUN.
- write high: issue suppressed; PC, buffer and output unaffected; an already issued read still completes.
- Reset mid-operation clears everything immediately, including in-flight read.

## Timing
- start sampled at edge k: addr = start_addr after k; first op_valid high after edge k+2.
- Throughput with op_ready held 1 and write 0: one op per cycle, consecutive PCs.
- jump sampled at edge j: op_valid low after j; first op from jump_addr valid after edge j+2.
- Backpressure: with op_ready 0, at most 2 ops buffered; issue resumes the cycle a pop frees credit; no op lost or duplicated.
- HALT_OP captured at edge h: halted = 1, busy = 0 after h; addr holds PC of the op after the halt op.

## Test plan
- Reset then start, start_addr = 3, mem[3..6] = 11,22,33,44, op_ready = 1 -> op_out 11,22,33,44 on consecutive cycles from edge k+2, op_pc 3,4,5,6.
- PC wrap: start_addr = 14, mem[14]=A1, mem[15]=A2, mem[0]=A3 -> op_pc 14,15,0 in order.
- op_ready low 5 cycles mid-stream -> at most 2 ops held, op_out stable, sequence resumes without gap or duplicate.
- jump to 9 while ops from 4,5 are buffered/in flight -> those discarded; next accepted op has op_pc 9 two edges later.
- mem[2] = 8'hFF, start at 0 -> ops 0,1 delivered, FF never presented, halted = 1; start again at 7 -> busy = 1, op_pc 7 next.
- write held high 3 cycles in RUN, then async rst mid-stream -> no issue during write, order preserved; after rst all outputs 0, state IDLE.
